seq_pattern_det: RTL
====================

# seq_pattern_det

Parametrised serial pattern detector and successor to the fixed 3-bit "101" detector. It watches a 1-bit qualified input stream and raises a one-cycle flag whenever the last `len` accepted bits equal a runtime-programmable pattern of up to `PAT_W` bits. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits in the serial receive path of the design, after bit recovery and before framing logic.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 16: match counter width.
- `LEN_W`, derived: `$clog2(PAT_W+1)`, width of the length fields.

- `clk` input 1: clock; all state is updated on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cfg_we` input 1: load configuration on this cycle.
- `cfg_pattern` input PAT_W: pattern; the first-received bit is `cfg_pattern[len-1]` and the last is `cfg_pattern[0]`.
- `cfg_len` input LEN_W: pattern length.
- `cfg_overlap` input 1: 1 = overlapping matches allowed; 0 = history is consumed on a match.
- `data_valid` input 1: `data_in` is accepted on this cycle.
- `data_in` input 1: serial data bit.
- `cnt_clr` input 1: clear the match counter.
- `flag` output 1: match pulse, registered.
- `match_cnt` output CNT_W: number of matches, saturating.
- `cnt_sat` output 1: sticky flag, set when `match_cnt` has saturated.

## Operation
- **Registers**
  - `pat`, `len`, `ovl`: active configuration.
  - `hist[PAT_W-1:0]`: shift register. On an accepted bit, `hist <= {hist[PAT_W-2:0], data_in}`.
  - `fill[LEN_W-1:0]`: count of valid history bits, saturating at `len`.
- **Reset values**
  - `pat` = 101 (zero-extended), `len` = 3, `ovl` = 1.
  - `hist` = 0, `fill` = 0, `flag` = 0, `match_cnt` = 0, `cnt_sat` = 0.
- **Priority:** `rst` > `cfg_we` > `data_valid`.
- **cfg_we**
  - Latches `pat`, `len`, `ovl`.
  - Clears `hist`, `fill` and `flag`.
  - A `data_valid` bit in the same cycle is dropped.
  - `match_cnt` and `cnt_sat` are untouched.
- **Length rules**
  - `cfg_len` > `PAT_W` is clamped to `PAT_W` at load.
  - `cfg_len` = 0 (or 1) is stored as-is; `len` = 0 disables detection, so `flag` never asserts.
- **Match condition**, evaluated on an accepted bit using the post-shift history:
  - `fill_next` ≥ `len`, and
  - `hist_next[len-1:0]` == `pat[len-1:0]`.
  - Bits at and above `len` are masked.
- **On a match**
  - `flag` <= 1 for exactly one cycle.
  - `match_cnt` increments.
  - If `ovl` = 0, `fill` <= 0; the next match needs `len` fresh bits.
  - If `ovl` = 1, `fill` is kept, so suffix/prefix overlaps match.
- **Idle cycles:** with `data_valid` = 0, `flag` <= 0 and `hist`/`fill` hold.
- **Counter**
  - Saturates at all ones and then sets `cnt_sat`.
  - `cnt_clr` clears `match_cnt` and `cnt_sat`.
  - If `cnt_clr` and a match occur in the same cycle, `match_cnt` <= 1.
- **Decision structure:** no FSM encoding beyond the `fill` counter. The match decision is purely a comparison on the shifted history. State is {`fill`=0..`len`} × `hist`.

## Timing
- **Latency:** `flag` asserts in the cycle after the rising edge that accepts the completing bit. This is the same visible timing as a Moore detector.
- **match_cnt** updates on that same edge, so it is visible together with `flag`.
- **Back-to-back matches:** with `ovl` = 1, `flag` can be high on consecutive accepted cycles. An example is pattern 11, `len` = 2, input 111 giving `flag` high on 2 cycles.
- **Gaps:** gaps in `data_valid` do not break a match in progress.
- **Reconfiguration:** a new configuration takes effect on the first accepted bit after the `cfg_we` cycle.
- **Reset mid-stream:** a partial match is discarded. A pending `flag` clears on the next edge.

## Test plan
- **Default mode.** Reset, then feed 1,0,1,0,1 with `data_valid` = 1 every cycle. Required: `flag` pulses after bit 3 and after bit 5; `match_cnt` = 2.
- **Non-overlap.** Set `cfg_overlap` = 0, pattern 101, `len` 3, then feed 10101. Required: exactly one `flag`, after bit 3; `match_cnt` = 1.
- **Full width.**
  - Set `len` = 8, pattern 0xA5, feed 0xA5 MSB-first with `data_valid` toggling 1,0. Required: one `flag` after the 8th accepted bit.
  - Feed 0xA4. Required: no `flag`.
- **Clamp and disable.**
  - Set `cfg_len` = 15 with `PAT_W` = 8. Required: behaves as `len` = 8.
  - Set `cfg_len` = 0, then feed 64 random bits. Required: `flag` stays 0.
- **Counter.**
  - With `CNT_W` = 2, produce 4 matches. Required: `match_cnt` = 3, `cnt_sat` = 1.
  - Assert `cnt_clr` in the same cycle as a 5th match. Required: `match_cnt` = 1, `cnt_sat` = 0.
- **Mid-stream events.**
  - Feed 1,0, then assert `rst` for 1 cycle, then feed 1. Required: no `flag`.
  - Repeat with `cfg_we` in place of `rst`, also driving `data_valid` = 1 on the `cfg_we` cycle. Required: that bit is dropped and there is no `flag`.

Source files
------------

// File: rtl/seq_pattern_det.sv
// Runtime-programmable serial pattern detector: flags when the last `len` accepted
// bits equal `pat`, with overlapping/non-overlapping modes and a saturating match count.
module seq_pattern_det #(
  parameter int  PAT_W = 8,
  parameter int  CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             cnt_clr,
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : l;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Ones in bit positions below l; history bits at and above len are ignored.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic             accept;
  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_nxt;
  logic [PAT_W-1:0] mask;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;

  // Match decision on the post-shift history of the bit accepted this cycle
  always_comb begin
    accept   = data_valid && !cfg_we;
    hist_nxt = {hist[PAT_W-2:0], data_in};
    fill_nxt = (fill >= len) ? len : LEN_W'(fill + 1'b1);
    mask     = len_mask(len);
    match    = accept && (len != '0) && (fill_nxt >= len) &&
               (((hist_nxt ^ pat) & mask) == '0);
    cnt_inc  = sat_inc(match_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= PAT_W'(3'b101);
      len  <= clamp_len(LEN_W'(3));
      ovl  <= 1'b1;
      hist <= '0;
      fill <= '0;
      flag <= 1'b0;
    end else if (cfg_we) begin
      pat  <= cfg_pattern;
      len  <= clamp_len(cfg_len);
      ovl  <= cfg_overlap;
      hist <= '0;
      fill <= '0;
      flag <= 1'b0;
    end else if (data_valid) begin
      hist <= hist_nxt;
      // Non-overlap mode consumes the history so the next match needs len fresh bits
      fill <= (match && !ovl) ? '0 : fill_nxt;
      flag <= match;
    end else begin
      flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (cnt_clr) begin
      match_cnt <= match ? CNT_W'(1) : '0;
      cnt_sat   <= 1'b0;
    end else if (match) begin
      match_cnt <= cnt_inc;
      if (cnt_inc == '1) cnt_sat <= 1'b1;
    end
  end

endmodule
